// File: rtl/tonegen_pkg.sv
// tonegen_pkg
// Shared definitions for the tone generator voices.
//   - Envelope state encodings (IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3)
//     and the enum type built from them.
//   - VOL_MAX: the largest amplitude the output mixer accepts.
package tonegen_pkg;

  localparam logic [1:0] ENV_IDLE    = 2'd0;
  localparam logic [1:0] ENV_ATTACK  = 2'd1;
  localparam logic [1:0] ENV_SUSTAIN = 2'd2;
  localparam logic [1:0] ENV_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ENV_IDLE,
    ATTACK  = ENV_ATTACK,
    SUSTAIN = ENV_SUSTAIN,
    RELEASE = ENV_RELEASE
  } env_state_t;

  localparam int unsigned VOL_MAX = 15;

endpackage

// File: rtl/tick_sync.sv
// tick_sync
// Brings the scaler's divided clock into the system clock domain as plain
// data and turns every rising edge of it into a single-cycle tick pulse.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active low
//   en       in   synchronous clear of the synchronizer when low
//   tick_clk in   divided clock from the scaler (data, not a clock)
//   tick     out  one clk cycle high per tick_clk rising edge
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick_clk,
  output logic tick
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 form the metastability synchronizer; s3 holds the previous
  // synchronized value so a 0->1 step between s3 and s2 marks an edge.
  // Clearing all three while disabled keeps tick quiet until re-enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else if (!en) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/tone_channel.sv
// tone_channel
// One voice of the tone generator: a square-wave oscillator and an
// attack/sustain/release volume envelope, both stepped by ticks derived
// from the scaler's divided clock.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active low
//   en            in   channel enable, low clears all state synchronously
//   tick_clk      in   divided clock from the scaler (rising edges used)
//   period        in   square half-period in ticks, 0 = silent
//   gate          in   note held
//   attack_rate   in   ticks per attack step minus 1
//   release_rate  in   ticks per release step minus 1
//   sustain_level in   attack target and sustain volume
//   square        out  oscillator output
//   volume        out  envelope level
//   sample        out  square ? volume : 0
//   busy          out  envelope not idle
module tone_channel
  import tonegen_pkg::*;
#(
  parameter int FREQ_W = 12,
  parameter int ENV_W  = 8,
  parameter int VOL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick_clk,
  input  logic [FREQ_W-1:0] period,
  input  logic              gate,
  input  logic [ENV_W-1:0]  attack_rate,
  input  logic [ENV_W-1:0]  release_rate,
  input  logic [VOL_W-1:0]  sustain_level,
  output logic              square,
  output logic [VOL_W-1:0]  volume,
  output logic [VOL_W-1:0]  sample,
  output logic              busy
);

  // The mixer never sees more than VOL_MAX; with the default 4-bit volume
  // this clamp is a no-op, it only matters for wider VOL_W builds.
  localparam logic [VOL_W-1:0] VOL_LIMIT = VOL_W'(VOL_MAX);

  logic              tick;
  logic [FREQ_W-1:0] ph;
  logic [ENV_W-1:0]  ec;
  logic [ENV_W-1:0]  ec_d;
  logic [VOL_W-1:0]  vol_d;
  logic [VOL_W-1:0]  attack_target;
  env_state_t        env_state;
  env_state_t        state_d;

  tick_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick_clk (tick_clk),
    .tick     (tick)
  );

  assign attack_target = (sustain_level > VOL_LIMIT) ? VOL_LIMIT : sustain_level;

  // Oscillator: count ticks up to period-1, then wrap and flip the output.
  // The >= compare lets a shortened period take effect on the very next
  // tick instead of counting all the way around the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph     <= '0;
      square <= 1'b0;
    end else if (!en) begin
      ph     <= '0;
      square <= 1'b0;
    end else if (tick) begin
      if (period == '0) begin
        ph     <= '0;
        square <= 1'b0;
      end else if (ph >= period - FREQ_W'(1)) begin
        ph     <= '0;
        square <= ~square;
      end else begin
        ph <= ph + FREQ_W'(1);
      end
    end
  end

  // Envelope next-state logic. Nothing moves between ticks; gate is only
  // looked at on a tick. Release checks whether the decremented volume
  // lands on zero so it reaches IDLE on that same tick.
  always_comb begin
    state_d = env_state;
    ec_d    = ec;
    vol_d   = volume;
    if (tick) begin
      case (env_state)
        IDLE: begin
          vol_d = '0;
          if (gate) begin
            state_d = ATTACK;
            ec_d    = '0;
          end
        end
        ATTACK: begin
          if (!gate) begin
            state_d = RELEASE;
            ec_d    = '0;
          end else if (volume >= attack_target) begin
            vol_d   = attack_target;
            state_d = SUSTAIN;
          end else if (ec >= attack_rate) begin
            ec_d  = '0;
            vol_d = volume + VOL_W'(1);
          end else begin
            ec_d = ec + ENV_W'(1);
          end
        end
        SUSTAIN: begin
          if (!gate) begin
            state_d = RELEASE;
            ec_d    = '0;
          end else begin
            vol_d = attack_target;
          end
        end
        RELEASE: begin
          if (gate) begin
            state_d = ATTACK;
            ec_d    = '0;
          end else if (volume == '0) begin
            state_d = IDLE;
          end else if (ec >= release_rate) begin
            ec_d  = '0;
            vol_d = volume - VOL_W'(1);
            if (volume == VOL_W'(1)) begin
              state_d = IDLE;
            end
          end else begin
            ec_d = ec + ENV_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Envelope registers; disabling the channel drops straight back to a
  // silent IDLE without running a release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      env_state <= IDLE;
      ec        <= '0;
      volume    <= '0;
    end else if (!en) begin
      env_state <= IDLE;
      ec        <= '0;
      volume    <= '0;
    end else begin
      env_state <= state_d;
      ec        <= ec_d;
      volume    <= vol_d;
    end
  end

  assign sample = square ? volume : '0;
  assign busy   = (env_state != IDLE);

endmodule
